// File: rtl/timer_pkg.sv
// Shared constants and state encoding for the timer interrupt controller.
// Imported by the edge detector and the controller top.
package timer_pkg;

    // Number of timer sources and width of a source index.
    localparam int NUM_SRC = 4;
    localparam int ID_W    = 2;

    // Presentation FSM: nothing on the line, or one source presented.
    typedef enum logic [0:0] {
        IRQ_IDLE   = 1'b0,
        IRQ_ASSERT = 1'b1
    } irq_state_t;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the timer tick lines.
// Keeps one cycle of history per source.
module tick_edge_det #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [W-1:0] tick_in,
    output logic [W-1:0] rise
);

    logic [W-1:0] hist;

    // History starts at 0 so a line already high at release counts once.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist <= '0;
        end else begin
            hist <= tick_in;
        end
    end

    // A level held high produces a single-cycle rise.
    assign rise = tick_in & ~hist;

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt aggregator: edge capture, pending/missed tracking,
// fixed-priority presentation of one source at a time to a consumer.
module timer_irq_ctrl #(
    parameter int NUM_SRC = timer_pkg::NUM_SRC,
    parameter int ID_W    = timer_pkg::ID_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] tick_in,
    input  logic [NUM_SRC-1:0] enable,
    input  logic               ack,
    input  logic               clear_missed,
    output logic               irq,
    output logic [ID_W-1:0]    irq_id,
    output logic [NUM_SRC-1:0] pending,
    output logic [NUM_SRC-1:0] missed
);

    import timer_pkg::*;

    irq_state_t         state;
    logic [NUM_SRC-1:0] rise;
    logic [NUM_SRC-1:0] ack_hit;
    logic [NUM_SRC-1:0] overrun;
    logic [NUM_SRC-1:0] pending_nxt;
    logic [NUM_SRC-1:0] missed_nxt;
    logic [ID_W-1:0]    pick;
    logic               found;
    logic               take_ack;

    tick_edge_det #(
        .W (NUM_SRC)
    ) u_edge (
        .clock   (clock),
        .reset   (reset),
        .tick_in (tick_in),
        .rise    (rise)
    );

    // An ack only counts while a request is actually on the line.
    assign take_ack = (state == IRQ_ASSERT) && ack;

    // One-hot mask of the presented source, active only on a taken ack.
    always_comb begin
        ack_hit = '0;
        if (take_ack) begin
            ack_hit = {{(NUM_SRC-1){1'b0}}, 1'b1} << irq_id;
        end
    end

    // Lowest-index pending source wins; only irq_id registers the choice.
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pending[i] && !found) begin
                pick  = ID_W'(i);
                found = 1'b1;
            end
        end
    end

    // A new edge beats an ack on the same source; disable clears outright.
    always_comb begin
        overrun     = rise & enable & pending & ~ack_hit;
        pending_nxt = enable & ((pending & ~ack_hit) | rise);
        missed_nxt  = (clear_missed ? '0 : missed) | overrun;
    end

    // Pending and sticky missed flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            pending <= '0;
            missed  <= '0;
        end else begin
            pending <= pending_nxt;
            missed  <= missed_nxt;
        end
    end

    // Presentation FSM; irq_id is latched on entry and held otherwise.
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IRQ_IDLE;
            irq_id <= '0;
        end else begin
            unique case (state)
                IRQ_IDLE: begin
                    if (found) begin
                        state  <= IRQ_ASSERT;
                        irq_id <= pick;
                    end
                end
                IRQ_ASSERT: begin
                    if (ack) begin
                        state <= IRQ_IDLE;
                    end
                end
            endcase
        end
    end

    assign irq = (state == IRQ_ASSERT);

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl with an expectation queue.
// Outputs are sampled 1 time unit after each rising clock edge.
module tb_timer_irq_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] tick_in;
    logic [3:0] enable;
    logic       ack;
    logic       clear_missed;
    logic       irq;
    logic [1:0] irq_id;
    logic [3:0] pending;
    logic [3:0] missed;

    int total = 0;
    int bad   = 0;

    logic [10:0] exp_q[$];

    timer_irq_ctrl dut (
        .clock        (clock),
        .reset        (reset),
        .tick_in      (tick_in),
        .enable       (enable),
        .ack          (ack),
        .clear_missed (clear_missed),
        .irq          (irq),
        .irq_id       (irq_id),
        .pending      (pending),
        .missed       (missed)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag);
        logic [10:0] obs;
        logic [10:0] e;
        obs = {irq, irq_id, pending, missed};
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL %s: no expectation queued, observed=%h", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) else begin
                bad++;
                $error("FAIL %s: observed irq/id/pend/miss=%b/%0d/%b/%b expected=%b/%0d/%b/%b",
                       tag, obs[10], obs[9:8], obs[7:4], obs[3:0],
                       e[10], e[9:8], e[7:4], e[3:0]);
            end
        end
    endtask

    // Queue the expected post-edge outputs, clock once, then compare.
    task automatic cyc(input string tag, input logic e_irq, input logic [1:0] e_id,
                       input logic [3:0] e_p, input logic [3:0] e_m);
        exp_q.push_back({e_irq, e_id, e_p, e_m});
        @(posedge clock);
        #1;
        check(tag);
    endtask

    initial begin
        reset = 1'b1; tick_in = '0; enable = 4'hF; ack = 1'b0; clear_missed = 1'b0;
        @(posedge clock); #1;
        cyc("reset", 0, 0, 4'b0000, 4'b0000);
        reset = 1'b0;

        // single pulse on source 2
        tick_in = 4'b0100; cyc("p2_pend", 0, 0, 4'b0100, 4'b0000);
        tick_in = 4'b0000; cyc("p2_irq",  1, 2, 4'b0100, 4'b0000);
        ack = 1'b1;        cyc("p2_ack",  0, 2, 4'b0000, 4'b0000);
        ack = 1'b0;

        // simultaneous sources 1 and 3
        tick_in = 4'b1010; cyc("s13_pend", 0, 2, 4'b1010, 4'b0000);
        tick_in = 4'b0000; cyc("s13_id1",  1, 1, 4'b1010, 4'b0000);
        cyc("s13_hold", 1, 1, 4'b1010, 4'b0000);
        ack = 1'b1;        cyc("s13_ack1", 0, 1, 4'b1000, 4'b0000);
        ack = 1'b0;        cyc("s13_id3",  1, 3, 4'b1000, 4'b0000);
        ack = 1'b1;        cyc("s13_ack3", 0, 3, 4'b0000, 4'b0000);
        ack = 1'b0;

        // higher-priority arrival does not disturb the presented id
        tick_in = 4'b0100; cyc("hp_pend", 0, 3, 4'b0100, 4'b0000);
        tick_in = 4'b0000; cyc("hp_id2",  1, 2, 4'b0100, 4'b0000);
        tick_in = 4'b0001; cyc("hp_keep", 1, 2, 4'b0101, 4'b0000);
        tick_in = 4'b0000; ack = 1'b1;
        cyc("hp_ack2", 0, 2, 4'b0001, 4'b0000);
        ack = 1'b0;        cyc("hp_id0",  1, 0, 4'b0001, 4'b0000);
        ack = 1'b1;        cyc("hp_ack0", 0, 0, 4'b0000, 4'b0000);

        // ack while idle is ignored
        cyc("idle_ack", 0, 0, 4'b0000, 4'b0000);
        ack = 1'b0;

        // overrun on source 0, clear, and overrun beating clear
        tick_in = 4'b0001; cyc("ov_pend", 0, 0, 4'b0001, 4'b0000);
        tick_in = 4'b0000; cyc("ov_irq",  1, 0, 4'b0001, 4'b0000);
        tick_in = 4'b0001; cyc("ov_miss", 1, 0, 4'b0001, 4'b0001);
        tick_in = 4'b0000; clear_missed = 1'b1;
        cyc("ov_clr", 1, 0, 4'b0001, 4'b0000);
        tick_in = 4'b0001;
        cyc("ov_win", 1, 0, 4'b0001, 4'b0001);
        tick_in = 4'b0000; clear_missed = 1'b0; ack = 1'b1;
        cyc("ov_ack", 0, 0, 4'b0000, 4'b0001);
        ack = 1'b0; clear_missed = 1'b1;
        cyc("ov_clr2", 0, 0, 4'b0000, 4'b0000);
        clear_missed = 1'b0;

        // disabled source dropped; held level counts once
        enable = 4'b1110;
        tick_in = 4'b0001; cyc("dis_0a", 0, 0, 4'b0000, 4'b0000);
        tick_in = 4'b0000; cyc("dis_0b", 0, 0, 4'b0000, 4'b0000);
        tick_in = 4'b0010; cyc("lvl_pend", 0, 0, 4'b0010, 4'b0000);
        cyc("lvl_irq", 1, 1, 4'b0010, 4'b0000);
        ack = 1'b1;        cyc("lvl_ack", 0, 1, 4'b0000, 4'b0000);
        ack = 1'b0;
        for (int i = 0; i < 7; i++) cyc("lvl_once", 0, 1, 4'b0000, 4'b0000);
        tick_in = 4'b0000; cyc("lvl_low", 0, 1, 4'b0000, 4'b0000);
        enable = 4'hF;

        // ack coinciding with a new edge on the presented source
        tick_in = 4'b1000; cyc("re_pend", 0, 1, 4'b1000, 4'b0000);
        tick_in = 4'b0000; cyc("re_irq",  1, 3, 4'b1000, 4'b0000);
        tick_in = 4'b1000; ack = 1'b1;
        cyc("re_gap", 0, 3, 4'b1000, 4'b0000);
        tick_in = 4'b0000; ack = 1'b0;
        cyc("re_again", 1, 3, 4'b1000, 4'b0000);
        ack = 1'b1;        cyc("re_ack", 0, 3, 4'b0000, 4'b0000);
        ack = 1'b0;

        // presented source disabled mid-request
        tick_in = 4'b0100; cyc("dm_pend", 0, 3, 4'b0100, 4'b0000);
        tick_in = 4'b0000; cyc("dm_irq",  1, 2, 4'b0100, 4'b0000);
        enable = 4'b1011;  cyc("dm_clr",  1, 2, 4'b0000, 4'b0000);
        cyc("dm_hold", 1, 2, 4'b0000, 4'b0000);
        ack = 1'b1;        cyc("dm_ack",  0, 2, 4'b0000, 4'b0000);
        ack = 1'b0; enable = 4'hF;
        cyc("dm_idle", 0, 2, 4'b0000, 4'b0000);

        // reset during a request with ack and clear_missed asserted
        tick_in = 4'b0001; cyc("rs_pend", 0, 2, 4'b0001, 4'b0000);
        tick_in = 4'b0000; cyc("rs_irq",  1, 0, 4'b0001, 4'b0000);
        tick_in = 4'b0001; cyc("rs_miss", 1, 0, 4'b0001, 4'b0001);
        tick_in = 4'b0000; reset = 1'b1; ack = 1'b1; clear_missed = 1'b1;
        cyc("rs_drop", 0, 0, 4'b0000, 4'b0000);
        reset = 1'b0; ack = 1'b0; clear_missed = 1'b0;
        cyc("rs_after", 0, 0, 4'b0000, 4'b0000);

        // line already high when reset releases
        reset = 1'b1; tick_in = 4'b0100;
        cyc("rh_rst", 0, 0, 4'b0000, 4'b0000);
        reset = 1'b0;      cyc("rh_pend", 0, 0, 4'b0100, 4'b0000);
        cyc("rh_irq", 1, 2, 4'b0100, 4'b0000);
        tick_in = 4'b0000; ack = 1'b1;
        cyc("rh_ack", 0, 2, 4'b0000, 4'b0000);
        ack = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
